music_seq_player: RTL



---
 rtl/music_pkg.sv | 41 ++++
 rtl/music_seq_player_tone_gen.sv | 98 +++++++++
 rtl/music_seq_player.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the music sequencer: player states, the note
// frequency table and the elaboration-time half-period helpers.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PLAY   = 3'd3,
    ST_PAUSED = 3'd4
  } state_e;

  localparam int unsigned N_NOTES = 16;

  // Index 0 is the rest; 1-7 and 8-14 are two diatonic octaves, 15 the top C.
  localparam logic [15:0][10:0] F_HZ = {
    11'd1047, 11'd988, 11'd880, 11'd784, 11'd698, 11'd659, 11'd587, 11'd523,
    11'd494,  11'd440, 11'd392, 11'd349, 11'd330, 11'd294, 11'd262, 11'd0
  };

  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input logic [3:0]  note);
    int unsigned f;
    f = 32'(F_HZ[note]);
    if (f == 32'd0) begin
      return 32'd0;
    end else begin
      return clk_hz / (32'd2 * f);
    end
  endfunction

  function automatic logic [N_NOTES*32-1:0] half_table(input int unsigned clk_hz);
    logic [N_NOTES*32-1:0] t;
    t = {(N_NOTES*32){1'b0}};
    for (int i = 0; i < 16; i++) begin
      t[i*32 +: 32] = half_period(clk_hz, 4'(i));
    end
    return t;
  endfunction

endpackage

// File: rtl/music_seq_player_tone_gen.sv
// One voice: holds the current note, divides the clock down to a square
// wave and flags the upper octave.
module tone_gen
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned NOTE_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NOTE_W-1:0] note_i,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic              run_i,
  input  logic              hold_i,
  output logic              speak_o,
  output logic              high_o
);

  localparam logic [N_NOTES*32-1:0] HALF_TAB = half_table(CLK_HZ);
  // Note 1 is the lowest pitch, so its half period is the largest count.
  localparam int unsigned HALF_W = $clog2(half_period(CLK_HZ, 4'd1) + 32'd1);
  localparam logic [NOTE_W-1:0] NOTE_REST = {NOTE_W{1'b0}};

  logic [NOTE_W-1:0] note_q, note_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              speak_q, speak_d;
  logic              high_q, high_d;
  logic [3:0]        note_idx_s;
  logic [31:0]       half_s;
  logic              wrap_s;

  assign note_idx_s = 4'(note_q);
  assign half_s     = HALF_TAB[{note_idx_s, 5'd0} +: 32];
  assign wrap_s     = (32'(cnt_q) == (half_s - 32'd1));

  // Pause keeps counter and phase so the wave resumes where it left off.
  always_comb begin
    note_d  = note_q;
    high_d  = high_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    speak_d = 1'b0;
    if (clr_i) begin
      note_d  = NOTE_REST;
      high_d  = 1'b0;
      cnt_d   = {HALF_W{1'b0}};
      phase_d = 1'b0;
    end else if (load_i && (note_i != note_q)) begin
      note_d = note_i;
      high_d = (note_i >= NOTE_W'(8));
      cnt_d  = {HALF_W{1'b0}};
      if (note_i == NOTE_REST) begin
        phase_d = 1'b0;
        speak_d = 1'b0;
      end else begin
        phase_d = phase_q;
        speak_d = phase_q;
      end
    end else if (hold_i) begin
      speak_d = 1'b0;
    end else if (run_i && (note_q != NOTE_REST)) begin
      if (wrap_s) begin
        cnt_d   = {HALF_W{1'b0}};
        phase_d = ~phase_q;
        speak_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + HALF_W'(1);
        speak_d = phase_q;
      end
    end else begin
      cnt_d   = {HALF_W{1'b0}};
      phase_d = 1'b0;
      speak_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      note_q  <= NOTE_REST;
      high_q  <= 1'b0;
      cnt_q   <= {HALF_W{1'b0}};
      phase_q <= 1'b0;
      speak_q <= 1'b0;
    end else begin
      note_q  <= note_d;
      high_q  <= high_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      speak_q <= speak_d;
    end
  end

  assign speak_o = speak_q;
  assign high_o  = high_q;

endmodule

// File: rtl/music_seq_player.sv
// Song sequencer: steps through an external synchronous ROM at the beat
// rate and drives N_CH square-wave voices from the fetched notes.
module music_seq_player
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned BEAT_HZ  = 4,
  parameter int unsigned N_CH     = 2,
  parameter int unsigned NOTE_W   = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SONG_LEN = 139
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     play,
  input  logic                     pause,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [N_CH*NOTE_W-1:0]   rom_data,
  output logic [N_CH-1:0]          speak,
  output logic [N_CH-1:0]          high,
  output logic [NOTE_W-1:0]        led,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned        BEAT_DIV  = CLK_HZ / BEAT_HZ;
  localparam int unsigned        BEAT_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BEAT_DIV - 32'd1);
  localparam logic [ADDR_W-1:0]  LAST_STEP = ADDR_W'(SONG_LEN - 32'd1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [NOTE_W-1:0]   led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                run_s, tick_s, new_step_s, load_s;
  logic                clr_s, run_nx_s, hold_s;

  // Step sequencing, beat counting and ROM addressing.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    beat_d     = beat_q;
    rom_addr_d = rom_addr_q;
    led_d      = led_q;
    done_d     = 1'b0;
    new_step_s = 1'b0;
    run_s  = (state_q == ST_FETCH) || (state_q == ST_WAIT) || (state_q == ST_PLAY);
    tick_s = run_s && (beat_q == BEAT_LAST);

    if (stop) begin
      state_d = ST_IDLE;
    end else if (tick_s) begin
      if (step_q != LAST_STEP) begin
        step_d     = step_q + ADDR_W'(1);
        state_d    = ST_FETCH;
        new_step_s = 1'b1;
      end else if (loop_en) begin
        step_d     = {ADDR_W{1'b0}};
        state_d    = ST_FETCH;
        new_step_s = 1'b1;
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (play) begin
            state_d    = ST_FETCH;
            step_d     = {ADDR_W{1'b0}};
            new_step_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: state_d = ST_WAIT;
        ST_WAIT:  state_d = ST_PLAY;
        ST_PLAY: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_PAUSED: begin
          if (play && !pause) begin
            state_d = ST_PLAY;
          end else begin
            state_d = ST_PAUSED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    load_s = (state_q == ST_WAIT) && (state_d != ST_IDLE);

    if (state_d == ST_IDLE) begin
      step_d     = {ADDR_W{1'b0}};
      beat_d     = {BEAT_W{1'b0}};
      rom_addr_d = {ADDR_W{1'b0}};
      led_d      = {NOTE_W{1'b0}};
    end else begin
      if (new_step_s) begin
        beat_d     = {BEAT_W{1'b0}};
        rom_addr_d = step_d;
      end else if (state_d == ST_PAUSED) begin
        beat_d = beat_q;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
      if (load_s) begin
        led_d = rom_data[NOTE_W-1:0];
      end else begin
        led_d = led_q;
      end
    end
  end

  // Voices follow the next state so their outputs line up with busy/led.
  assign busy_d   = (state_d != ST_IDLE);
  assign clr_s    = (state_d == ST_IDLE);
  assign hold_s   = (state_d == ST_PAUSED);
  assign run_nx_s = (state_d == ST_FETCH) || (state_d == ST_WAIT) || (state_d == ST_PLAY);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= {ADDR_W{1'b0}};
      rom_addr_q <= {ADDR_W{1'b0}};
      beat_q     <= {BEAT_W{1'b0}};
      led_q      <= {NOTE_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      rom_addr_q <= rom_addr_d;
      beat_q     <= beat_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_voice
    tone_gen #(
      .CLK_HZ (CLK_HZ),
      .NOTE_W (NOTE_W)
    ) u_tone (
      .clk_i   (sys_clk),
      .rst_ni  (sys_rst_n),
      .note_i  (rom_data[k*NOTE_W +: NOTE_W]),
      .load_i  (load_s),
      .clr_i   (clr_s),
      .run_i   (run_nx_s),
      .hold_i  (hold_s),
      .speak_o (speak[k]),
      .high_o  (high[k])
    );
  end

  assign rom_addr = rom_addr_q;
  assign led      = led_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
